// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
//  Module   : mem_access_unit
//  Purpose  : MEM stage of a 5-stage pipeline. Turns EX/MEM load/store control
//             into a request/acknowledge handshake with data memory. It stalls
//             the upstream pipeline while an access is outstanding, aborts an
//             access after TIMEOUT cycles without acknowledge, and drives the
//             MEM/WB register outputs.
//  Ports    : clk_i, rst_i            clock, synchronous active-high reset
//             wb_i, memread_i,
//             memwrite_i, addr_i,
//             wdata_i, writeaddr_i    EX/MEM register contents
//             mem_req_o, mem_we_o,
//             mem_addr_o, mem_wdata_o request side of the data-memory port
//             mem_ack_i, mem_rdata_i  completion side of the data-memory port
//             stall_o                 freezes IF/ID/EX and EX/MEM while high
//             wb_o, rdata_o,
//             result_o, writeaddr_o   MEM/WB register outputs
//             err_o                   sticky timeout / misalignment flag
//  Revision : 1.0  initial release
// ============================================================================
module mem_access_unit #(
    parameter int TIMEOUT = 64
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [1:0]  wb_i,
    input  logic        memread_i,
    input  logic        memwrite_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    input  logic [4:0]  writeaddr_i,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_rdata_i,
    output logic        stall_o,
    output logic [1:0]  wb_o,
    output logic [31:0] rdata_o,
    output logic [31:0] result_o,
    output logic [4:0]  writeaddr_o,
    output logic        err_o
);

    localparam logic [0:0] c_IDLE     = 1'b0;
    localparam logic [0:0] c_BUSY     = 1'b1;
    localparam logic [7:0] c_CNT_LAST = 8'(TIMEOUT - 1);

    logic [0:0]  r_state;
    logic [7:0]  r_cnt;
    logic        r_req;
    logic        r_we;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [1:0]  r_lat_wb;
    logic [4:0]  r_lat_waddr;
    logic [1:0]  r_wb;
    logic [31:0] r_rdata;
    logic [31:0] r_result;
    logic [4:0]  r_waddr;
    logic        r_err;

    logic w_access;
    logic w_aligned;
    logic w_start;
    logic w_misaligned;
    logic w_busy;

    assign w_access     = memread_i | memwrite_i;
    assign w_aligned    = (addr_i[1:0] == 2'b00);
    assign w_start      = (r_state == c_IDLE) & w_access & w_aligned;
    assign w_misaligned = (r_state == c_IDLE) & w_access & ~w_aligned;
    assign w_busy       = (r_state == c_BUSY);

    // The ack cycle releases the pipeline so the next instruction can advance
    // in the same edge that retires the access.
    assign stall_o = ~rst_i & (w_start | (w_busy & ~mem_ack_i));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= c_IDLE;
            r_cnt       <= 8'd0;
            r_req       <= 1'b0;
            r_we        <= 1'b0;
            r_addr      <= 32'd0;
            r_wdata     <= 32'd0;
            r_lat_wb    <= 2'b00;
            r_lat_waddr <= 5'd0;
            r_wb        <= 2'b00;
            r_rdata     <= 32'd0;
            r_result    <= 32'd0;
            r_waddr     <= 5'd0;
            r_err       <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_start) begin
                        // A simultaneous read+write request is treated as a store.
                        r_state     <= c_BUSY;
                        r_cnt       <= 8'd0;
                        r_req       <= 1'b1;
                        r_we        <= memwrite_i;
                        r_addr      <= {addr_i[31:2], 2'b00};
                        r_wdata     <= wdata_i;
                        r_lat_wb    <= wb_i;
                        r_lat_waddr <= writeaddr_i;
                        r_wb        <= 2'b00;
                    end else if (w_misaligned) begin
                        // Misaligned access is dropped as a bubble, never issued.
                        r_err <= 1'b1;
                        r_wb  <= 2'b00;
                    end else begin
                        r_wb     <= wb_i;
                        r_result <= addr_i;
                        r_waddr  <= writeaddr_i;
                    end
                end
                c_BUSY: begin
                    if (mem_ack_i) begin
                        r_state <= c_IDLE;
                        r_req   <= 1'b0;
                        if (!r_we) begin
                            r_rdata <= mem_rdata_i;
                        end
                        r_wb     <= r_lat_wb;
                        r_result <= r_addr;
                        r_waddr  <= r_lat_waddr;
                    end else if (r_cnt == c_CNT_LAST) begin
                        r_state <= c_IDLE;
                        r_req   <= 1'b0;
                        r_err   <= 1'b1;
                        r_wb    <= 2'b00;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                        r_wb  <= 2'b00;
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                    r_req   <= 1'b0;
                end
            endcase
        end
    end

    assign mem_req_o   = r_req;
    assign mem_we_o    = r_we;
    assign mem_addr_o  = r_addr;
    assign mem_wdata_o = r_wdata;
    assign wb_o        = r_wb;
    assign rdata_o     = r_rdata;
    assign result_o    = r_result;
    assign writeaddr_o = r_waddr;
    assign err_o       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_access_unit
//  Purpose  : Directed self-checking bench for mem_access_unit (TIMEOUT=4).
//             Expected MEM/WB writebacks are queued when an instruction is
//             driven and compared when the unit retires it.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mem_access_unit;

    logic        clk_i;
    logic        rst_i;
    logic [1:0]  wb_i;
    logic        memread_i;
    logic        memwrite_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic [4:0]  writeaddr_i;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic        mem_ack_i;
    logic [31:0] mem_rdata_i;
    logic        stall_o;
    logic [1:0]  wb_o;
    logic [31:0] rdata_o;
    logic [31:0] result_o;
    logic [4:0]  writeaddr_o;
    logic        err_o;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [1:0]  wb;
        logic [31:0] res;
        logic [4:0]  wa;
        logic [31:0] rd;
    } exp_t;

    exp_t sb_q[$];

    mem_access_unit #(.TIMEOUT(4)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .wb_i        (wb_i),
        .memread_i   (memread_i),
        .memwrite_i  (memwrite_i),
        .addr_i      (addr_i),
        .wdata_i     (wdata_i),
        .writeaddr_i (writeaddr_i),
        .mem_req_o   (mem_req_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_ack_i   (mem_ack_i),
        .mem_rdata_i (mem_rdata_i),
        .stall_o     (stall_o),
        .wb_o        (wb_o),
        .rdata_o     (rdata_o),
        .result_o    (result_o),
        .writeaddr_o (writeaddr_o),
        .err_o       (err_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "simulation did not terminate");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_inputs();
        wb_i        = 2'b00;
        memread_i   = 1'b0;
        memwrite_i  = 1'b0;
        addr_i      = 32'd0;
        wdata_i     = 32'd0;
        writeaddr_i = 5'd0;
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_req"},   32'(mem_req_o),   32'd0);
        chk({tag, "_we"},    32'(mem_we_o),    32'd0);
        chk({tag, "_maddr"}, mem_addr_o,       32'd0);
        chk({tag, "_mwdat"}, mem_wdata_o,      32'd0);
        chk({tag, "_wb"},    32'(wb_o),        32'd0);
        chk({tag, "_rdata"}, rdata_o,          32'd0);
        chk({tag, "_res"},   result_o,         32'd0);
        chk({tag, "_waddr"}, 32'(writeaddr_o), 32'd0);
        chk({tag, "_err"},   32'(err_o),       32'd0);
    endtask

    task automatic check_wb(input string tag);
        exp_t e;
        checks++;
        assert (sb_q.size() != 0) else begin
            failures++;
            $error("FAIL %s_queue observed=empty expected=entry", tag);
        end
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            chk({tag, "_wb"},    32'(wb_o),        32'(e.wb));
            chk({tag, "_res"},   result_o,         e.res);
            chk({tag, "_waddr"}, 32'(writeaddr_o), 32'(e.wa));
            chk({tag, "_rdata"}, rdata_o,          e.rd);
        end
    endtask

    // Drives one memory instruction, holding it (as a frozen EX/MEM register
    // would) until the unit retires or aborts it. ack_at=0 means never ack.
    task automatic mem_op(input string tag, input logic rd, input logic wr,
                          input logic [31:0] a, input logic [31:0] wd,
                          input logic [1:0] wb, input logic [4:0] wa,
                          input int ack_at, input logic [31:0] rdat,
                          output int n_stall, output int n_req);
        memread_i   = rd;
        memwrite_i  = wr;
        addr_i      = a;
        wdata_i     = wd;
        wb_i        = wb;
        writeaddr_i = wa;
        n_stall     = 0;
        n_req       = 0;
        #1;
        if (stall_o) n_stall++;
        for (int c = 1; c <= 16; c++) begin
            @(posedge clk_i);
            #1;
            if (!mem_req_o) break;
            n_req++;
            chk({tag, "_bubble"}, 32'(wb_o),     32'd0);
            chk({tag, "_maddr"},  mem_addr_o,    {a[31:2], 2'b00});
            chk({tag, "_mwe"},    32'(mem_we_o), 32'(wr));
            chk({tag, "_mwdat"},  mem_wdata_o,   wd);
            if (c == ack_at) begin
                mem_ack_i   = 1'b1;
                mem_rdata_i = rdat;
            end
            #1;
            if (stall_o) n_stall++;
            if (c == ack_at) begin
                @(posedge clk_i);
                #1;
                mem_ack_i = 1'b0;
                break;
            end
        end
    endtask

    initial begin
        int ns;
        int nr;
        exp_t e;

        rst_i       = 1'b1;
        mem_ack_i   = 1'b0;
        mem_rdata_i = 32'd0;
        idle_inputs();
        memread_i   = 1'b1;
        addr_i      = 32'h100;
        step();
        step();
        chk("rst_stall", 32'(stall_o), 32'd0);
        check_reset_vals("rst");
        idle_inputs();
        rst_i = 1'b0;
        step();

        // ALU passthrough
        wb_i = 2'b10; addr_i = 32'h1234; writeaddr_i = 5'd5;
        #1;
        chk("alu_stall", 32'(stall_o), 32'd0);
        e = '{wb: 2'b10, res: 32'h1234, wa: 5'd5, rd: 32'd0};
        sb_q.push_back(e);
        step();
        check_wb("alu");
        chk("alu_req", 32'(mem_req_o), 32'd0);

        // Load at 0x100, ack in third BUSY cycle
        e = '{wb: 2'b11, res: 32'h100, wa: 5'd7, rd: 32'hDEADBEEF};
        sb_q.push_back(e);
        mem_op("ld", 1'b1, 1'b0, 32'h100, 32'h0, 2'b11, 5'd7, 3, 32'hDEADBEEF, ns, nr);
        chk("ld_nreq",   32'(nr), 32'd3);
        chk("ld_nstall", 32'(ns), 32'd3);
        check_wb("ld");
        chk("ld_req_done", 32'(mem_req_o), 32'd0);

        // Store with read+write both set; rdata must not change
        e = '{wb: 2'b01, res: 32'h204, wa: 5'd9, rd: 32'hDEADBEEF};
        sb_q.push_back(e);
        mem_op("st", 1'b1, 1'b1, 32'h204, 32'hA5A5A5A5, 2'b01, 5'd9, 2, 32'h11111111, ns, nr);
        chk("st_nreq",   32'(nr), 32'd2);
        chk("st_nstall", 32'(ns), 32'd2);
        check_wb("st");

        // Back-to-back load issued in the cycle right after completion
        e = '{wb: 2'b10, res: 32'h40, wa: 5'd3, rd: 32'hCAFEF00D};
        sb_q.push_back(e);
        mem_op("b2b", 1'b1, 1'b0, 32'h40, 32'h0, 2'b10, 5'd3, 1, 32'hCAFEF00D, ns, nr);
        chk("b2b_nreq",   32'(nr), 32'd1);
        chk("b2b_nstall", 32'(ns), 32'd1);
        check_wb("b2b");

        // Stray ack while IDLE with an ALU op in flight
        idle_inputs();
        wb_i = 2'b01; addr_i = 32'h55; writeaddr_i = 5'd2;
        mem_ack_i = 1'b1; mem_rdata_i = 32'h99999999;
        e = '{wb: 2'b01, res: 32'h55, wa: 5'd2, rd: 32'hCAFEF00D};
        sb_q.push_back(e);
        step();
        mem_ack_i = 1'b0;
        check_wb("idleack");
        chk("idleack_req", 32'(mem_req_o), 32'd0);
        chk("idleack_err", 32'(err_o),     32'd0);

        // Reset from a populated state clears everything
        idle_inputs();
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        check_reset_vals("rst2");

        // Misaligned load after a normal ALU op
        wb_i = 2'b10; addr_i = 32'h77; writeaddr_i = 5'd6;
        e = '{wb: 2'b10, res: 32'h77, wa: 5'd6, rd: 32'd0};
        sb_q.push_back(e);
        step();
        check_wb("alu2");
        memread_i = 1'b1; addr_i = 32'h103; wb_i = 2'b11; writeaddr_i = 5'd4;
        #1;
        chk("mis_stall", 32'(stall_o), 32'd0);
        step();
        chk("mis_req",   32'(mem_req_o), 32'd0);
        chk("mis_err",   32'(err_o),     32'd1);
        chk("mis_wb",    32'(wb_o),      32'd0);
        chk("mis_res",   result_o,       32'h77);
        idle_inputs();
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        chk("rst3_err", 32'(err_o), 32'd0);

        // Timeout: no ack ever, TIMEOUT=4
        mem_op("to", 1'b1, 1'b0, 32'h8, 32'h0, 2'b11, 5'd8, 0, 32'h0, ns, nr);
        chk("to_nreq",   32'(nr), 32'd4);
        chk("to_nstall", 32'(ns), 32'd5);
        chk("to_err",    32'(err_o), 32'd1);
        chk("to_wb",     32'(wb_o),  32'd0);
        idle_inputs();
        #1;
        chk("to_idle_stall", 32'(stall_o), 32'd0);
        step();
        chk("to_idle_req",   32'(mem_req_o), 32'd0);

        // Reset in the second BUSY cycle, then a late ack
        memread_i = 1'b1; addr_i = 32'h300; wb_i = 2'b11; writeaddr_i = 5'd12;
        step();
        chk("rb_req1", 32'(mem_req_o), 32'd1);
        step();
        rst_i = 1'b1;
        #1;
        chk("rb_stall_in_rst", 32'(stall_o), 32'd0);
        step();
        rst_i = 1'b0;
        idle_inputs();
        check_reset_vals("rb");
        #1;
        chk("rb_stall", 32'(stall_o), 32'd0);
        mem_ack_i = 1'b1; mem_rdata_i = 32'h12345678;
        step();
        mem_ack_i = 1'b0;
        chk("rb_ack_rdata", rdata_o,         32'd0);
        chk("rb_ack_wb",    32'(wb_o),       32'd0);
        chk("rb_ack_req",   32'(mem_req_o),  32'd0);

        checks++;
        assert (sb_q.size() == 0) else begin
            failures++;
            $error("FAIL sb_leftover observed=%0d expected=0", sb_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
